// File: rtl/ysyx_22050550_wbu_pkg.sv
// Shared definitions for the write-back unit.
// Contents:
//   - CSR addresses.
//   - wbcsren bit positions.
//   - mstatus field positions.
//   - FSM state encoding.
//   - mstatus rewrite helpers used on trap entry and on return.
package ysyx_22050550_wbu_pkg;

    // CSR addresses (machine mode)
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // wbcsren bit indices; bits 6..7 are never driven
    localparam int EN_MEPC    = 0;
    localparam int EN_MCAUSE  = 1;
    localparam int EN_MTVEC   = 2;
    localparam int EN_MSTATUS = 3;
    localparam int EN_MIE     = 4;
    localparam int EN_MIP     = 5;

    // mstatus fields
    localparam int MS_MIE    = 3;
    localparam int MS_MPIE   = 7;
    localparam int MS_MPP_LO = 11;
    localparam int MS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_TRAP2  = 2'd2
    } wbu_state_e;

    // Trap entry: stash MIE into MPIE, mask interrupts, record M-mode as previous privilege.
    function automatic logic [63:0] mstatus_trap(input logic [63:0] s);
        logic [63:0] r;
        r                      = s;
        r[MS_MPIE]             = s[MS_MIE];
        r[MS_MIE]              = 1'b0;
        r[MS_MPP_HI:MS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // Trap return: restore MIE from MPIE, set MPIE, drop previous privilege to U.
    function automatic logic [63:0] mstatus_mret(input logic [63:0] s);
        logic [63:0] r;
        r                      = s;
        r[MS_MIE]              = s[MS_MPIE];
        r[MS_MPIE]             = 1'b1;
        r[MS_MPP_HI:MS_MPP_LO] = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050550_wbu_csrdec.sv
// CSR address decoder (combinational).
// Ports:
//   csr_wen, csr_addr  CSR write request.
//   csr_en[7:0]        one-hot enable, or zero if the address is unmapped or there is no write.
module ysyx_22050550_wbu_csrdec
    import ysyx_22050550_wbu_pkg::*;
(
    input  logic        csr_wen,
    input  logic [11:0] csr_addr,
    output logic [7:0]  csr_en
);

    always_comb begin
        csr_en = '0;
        if (csr_wen) begin
            case (csr_addr)
                CSR_MEPC:    csr_en[EN_MEPC]    = 1'b1;
                CSR_MCAUSE:  csr_en[EN_MCAUSE]  = 1'b1;
                CSR_MTVEC:   csr_en[EN_MTVEC]   = 1'b1;
                CSR_MSTATUS: csr_en[EN_MSTATUS] = 1'b1;
                CSR_MIE:     csr_en[EN_MIE]     = 1'b1;
                CSR_MIP:     csr_en[EN_MIP]     = 1'b1;
                default:     csr_en             = '0;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22050550_wbu.sv
// Write-back unit: the last pipeline stage, in front of the register/CSR file.
// Latches one retiring instruction per handshake. It then drives:
//   - the GPR write port;
//   - the CSR write enables and data;
//   - the commit strobe;
//   - the fetch redirect.
// ecall takes two cycles: mepc/mcause are written first, then mstatus plus the redirect.
// Ports:
//   clock, reset (async, active low)
//   in_* : upstream handshake and instruction fields
//   mepc/mtvec/mstatus : current CSR values
//   io_w* : GPR write port
//   wb* / wbcsren : CSR write data and enables
//   redirect_* : fetch redirect
//   commit_* : retire indication
// Optional feature: define YSYX_22050550_WBU_MINSTRET_EN to add the minstret counter output.
module ysyx_22050550_wbu
    import ysyx_22050550_wbu_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_wen,
    input  logic [XLEN-1:0] in_rd_data,
    input  logic            in_csr_wen,
    input  logic [11:0]     in_csr_addr,
    input  logic [XLEN-1:0] in_csr_wdata,
    input  logic            in_ecall,
    input  logic            in_mret,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mstatus,
    output logic [4:0]      io_waddr,
    output logic [XLEN-1:0] io_wdata,
    output logic            io_wen,
    output logic [XLEN-1:0] wbmepc,
    output logic [XLEN-1:0] wbmcause,
    output logic [XLEN-1:0] wbmtvec,
    output logic [XLEN-1:0] wbmstatus,
    output logic [XLEN-1:0] wbmie,
    output logic [XLEN-1:0] wbmip,
    output logic [7:0]      wbcsren,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc
`ifdef YSYX_22050550_WBU_MINSTRET_EN
    ,
    output logic [63:0]     minstret
`endif
);

    wbu_state_e      state;
    logic            accept;

    // latched instruction
    logic [XLEN-1:0] l_pc, l_rd_data, l_csr_wdata;
    logic [4:0]      l_rd;
    logic [11:0]     l_csr_addr;
    logic            l_rd_wen, l_csr_wen, l_ecall, l_mret;

    // last driven value of each data bus, so buses hold while their enable is low
    logic [4:0]      waddr_q;
    logic [XLEN-1:0] wdata_q, mepc_q, mcause_q, mtvec_q, mstatus_q, mie_q, mip_q;
    logic [XLEN-1:0] redir_q, cpc_q;

    logic [7:0]      dec_en;
    logic            in_commit, in_trap2;

    assign in_commit = (state == ST_COMMIT);
    assign in_trap2  = (state == ST_TRAP2);
    // An ecall in COMMIT must move to TRAP2, so it cannot take a new instruction.
    assign in_ready  = (state == ST_IDLE) || (in_commit && !l_ecall);
    assign accept    = in_valid && in_ready;

    ysyx_22050550_wbu_csrdec u_csrdec (
        .csr_wen  (l_csr_wen),
        .csr_addr (l_csr_addr),
        .csr_en   (dec_en)
    );

    always_comb begin
        wbcsren = '0;
        if (in_commit) begin
            if (l_ecall) begin
                wbcsren[EN_MEPC]   = 1'b1;
                wbcsren[EN_MCAUSE] = 1'b1;
            end else begin
                wbcsren = dec_en;
                if (l_mret) wbcsren[EN_MSTATUS] = 1'b1;
            end
        end else if (in_trap2) begin
            wbcsren[EN_MSTATUS] = 1'b1;
        end
    end

    assign io_wen         = in_commit && !l_ecall && l_rd_wen && (l_rd != 5'd0);
    assign commit_valid   = in_commit;
    assign redirect_valid = in_trap2 || (in_commit && l_mret);

    assign io_waddr  = io_wen ? l_rd      : waddr_q;
    assign io_wdata  = io_wen ? l_rd_data : wdata_q;
    assign commit_pc = in_commit ? l_pc : cpc_q;
    assign wbmepc    = wbcsren[EN_MEPC]   ? (l_ecall ? l_pc : l_csr_wdata) : mepc_q;
    assign wbmcause  = wbcsren[EN_MCAUSE] ? (l_ecall ? ECALL_CAUSE : l_csr_wdata) : mcause_q;
    assign wbmtvec   = wbcsren[EN_MTVEC]  ? l_csr_wdata : mtvec_q;
    assign wbmie     = wbcsren[EN_MIE]    ? l_csr_wdata : mie_q;
    assign wbmip     = wbcsren[EN_MIP]    ? l_csr_wdata : mip_q;
    // mstatus is taken live from the register file in the cycle it is rewritten
    assign wbmstatus = !wbcsren[EN_MSTATUS] ? mstatus_q :
                       in_trap2             ? mstatus_trap(mstatus) :
                       l_mret               ? mstatus_mret(mstatus) : l_csr_wdata;
    assign redirect_pc = !redirect_valid ? redir_q : (in_trap2 ? mtvec : mepc);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            l_pc        <= '0;
            l_rd        <= '0;
            l_rd_wen    <= 1'b0;
            l_rd_data   <= '0;
            l_csr_wen   <= 1'b0;
            l_csr_addr  <= '0;
            l_csr_wdata <= '0;
            l_ecall     <= 1'b0;
            l_mret      <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            mepc_q      <= '0;
            mcause_q    <= '0;
            mtvec_q     <= '0;
            mstatus_q   <= '0;
            mie_q       <= '0;
            mip_q       <= '0;
            redir_q     <= '0;
            cpc_q       <= '0;
        end else begin
            case (state)
                ST_IDLE:   if (accept) state <= ST_COMMIT;
                ST_COMMIT: state <= l_ecall ? ST_TRAP2 : (accept ? ST_COMMIT : ST_IDLE);
                ST_TRAP2:  state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
            if (accept) begin
                l_pc        <= in_pc;
                l_rd        <= in_rd;
                l_rd_wen    <= in_rd_wen;
                l_rd_data   <= in_rd_data;
                l_csr_wen   <= in_csr_wen;
                l_csr_addr  <= in_csr_addr;
                l_csr_wdata <= in_csr_wdata;
                l_ecall     <= in_ecall;
                l_mret      <= in_mret;
            end
            waddr_q   <= io_waddr;
            wdata_q   <= io_wdata;
            mepc_q    <= wbmepc;
            mcause_q  <= wbmcause;
            mtvec_q   <= wbmtvec;
            mstatus_q <= wbmstatus;
            mie_q     <= wbmie;
            mip_q     <= wbmip;
            redir_q   <= redirect_pc;
            cpc_q     <= commit_pc;
        end
    end

`ifdef YSYX_22050550_WBU_MINSTRET_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         minstret <= '0;
        else if (in_commit) minstret <= minstret + 64'd1;
    end
`endif

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && in_valid) begin
            assert (!(in_ecall && in_mret))
                else $error("wbu: in_ecall and in_mret both high");
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050550_wbu.sv
module tb_ysyx_22050550_wbu;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_rd_data, in_csr_wdata;
    logic [4:0]  in_rd;
    logic        in_rd_wen, in_csr_wen, in_ecall, in_mret;
    logic [11:0] in_csr_addr;
    logic [63:0] mepc, mtvec, mstatus;
    logic [4:0]  io_waddr;
    logic [63:0] io_wdata;
    logic        io_wen;
    logic [63:0] wbmepc, wbmcause, wbmtvec, wbmstatus, wbmie, wbmip;
    logic [7:0]  wbcsren;
    logic        redirect_valid, commit_valid;
    logic [63:0] redirect_pc, commit_pc;
`ifdef YSYX_22050550_WBU_MINSTRET_EN
    logic [63:0] minstret;
`endif

    int checks = 0;
    int errors = 0;

    ysyx_22050550_wbu dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_rd_data(in_rd_data),
        .in_csr_wen(in_csr_wen), .in_csr_addr(in_csr_addr), .in_csr_wdata(in_csr_wdata),
        .in_ecall(in_ecall), .in_mret(in_mret),
        .mepc(mepc), .mtvec(mtvec), .mstatus(mstatus),
        .io_waddr(io_waddr), .io_wdata(io_wdata), .io_wen(io_wen),
        .wbmepc(wbmepc), .wbmcause(wbmcause), .wbmtvec(wbmtvec),
        .wbmstatus(wbmstatus), .wbmie(wbmie), .wbmip(wbmip), .wbcsren(wbcsren),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .commit_valid(commit_valid), .commit_pc(commit_pc)
`ifdef YSYX_22050550_WBU_MINSTRET_EN
        , .minstret(minstret)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            end
    endtask

    // advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_pc = '0; in_rd = '0; in_rd_wen = 1'b0;
        in_rd_data = '0; in_csr_wen = 1'b0; in_csr_addr = '0; in_csr_wdata = '0;
        in_ecall = 1'b0; in_mret = 1'b0; mepc = '0; mtvec = '0; mstatus = '0;
        tick(); tick();
        chk("rst_io_wen", io_wen, 0);
        chk("rst_wbcsren", wbcsren, 0);
        chk("rst_commit", commit_valid, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_io_wdata", io_wdata, 0);
        chk("rst_wbmstatus", wbmstatus, 0);
        @(negedge clock) reset = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);

        // add x5 = 0x1234
        in_valid = 1'b1; in_pc = 64'h8000_0000; in_rd = 5'd5; in_rd_wen = 1'b1; in_rd_data = 64'h1234;
        tick();
        chk("add_io_wen", io_wen, 1);
        chk("add_io_waddr", io_waddr, 5);
        chk("add_io_wdata", io_wdata, 64'h1234);
        chk("add_commit", commit_valid, 1);
        chk("add_commit_pc", commit_pc, 64'h8000_0000);
        chk("add_in_ready", in_ready, 1);

        // back-to-back write to x0: suppressed, bus holds previous data
        in_pc = 64'h8000_0004; in_rd = 5'd0; in_rd_data = 64'hFF;
        tick();
        chk("x0_io_wen", io_wen, 0);
        chk("x0_commit", commit_valid, 1);
        chk("x0_io_wdata_hold", io_wdata, 64'h1234);

        // csrw mtvec, then unmapped CSR
        in_rd_wen = 1'b0; in_csr_wen = 1'b1; in_csr_addr = 12'h305; in_csr_wdata = 64'h8000_0100;
        tick();
        chk("csrw_en", wbcsren, 8'h04);
        chk("csrw_mtvec", wbmtvec, 64'h8000_0100);
        in_csr_addr = 12'h7C0; in_csr_wdata = 64'hDEAD;
        tick();
        chk("unmapped_en", wbcsren, 8'h00);
        chk("unmapped_commit", commit_valid, 1);
        chk("unmapped_mtvec_hold", wbmtvec, 64'h8000_0100);
        in_valid = 1'b0; in_csr_wen = 1'b0;
        tick();
        chk("idle_commit", commit_valid, 0);
        chk("idle_en", wbcsren, 0);
        chk("idle_in_ready", in_ready, 1);

        // ecall with GPR and CSR writes that must be suppressed
        mstatus = 64'hA_0000_1808; mtvec = 64'h8000_0100;
        in_valid = 1'b1; in_pc = 64'h8000_0040; in_ecall = 1'b1;
        in_rd = 5'd7; in_rd_wen = 1'b1; in_rd_data = 64'h55;
        in_csr_wen = 1'b1; in_csr_addr = 12'h305; in_csr_wdata = 64'hBAD;
        tick();
        in_valid = 1'b0; in_ecall = 1'b0; in_rd_wen = 1'b0; in_csr_wen = 1'b0;
        chk("ecall_en", wbcsren, 8'h03);
        chk("ecall_mepc", wbmepc, 64'h8000_0040);
        chk("ecall_mcause", wbmcause, 64'd11);
        chk("ecall_io_wen", io_wen, 0);
        chk("ecall_commit", commit_valid, 1);
        chk("ecall_mtvec_hold", wbmtvec, 64'h8000_0100);
        chk("ecall_no_redirect", redirect_valid, 0);
        tick();
        chk("trap2_in_ready", in_ready, 0);
        chk("trap2_en", wbcsren, 8'h08);
        chk("trap2_mstatus", wbmstatus, 64'hA_0000_1880);
        chk("trap2_redirect", redirect_valid, 1);
        chk("trap2_redirect_pc", redirect_pc, 64'h8000_0100);
        chk("trap2_commit", commit_valid, 0);
        tick();
        chk("post_trap_redirect", redirect_valid, 0);
        chk("post_trap_en", wbcsren, 0);
        chk("post_trap_in_ready", in_ready, 1);
        chk("post_trap_mstatus_hold", wbmstatus, 64'hA_0000_1880);

        // mret
        mstatus = 64'hA_0000_1880; mepc = 64'h8000_0044;
        in_valid = 1'b1; in_mret = 1'b1; in_pc = 64'h8000_0100;
        tick();
        in_valid = 1'b0; in_mret = 1'b0;
        chk("mret_en", wbcsren, 8'h08);
        chk("mret_mstatus", wbmstatus, 64'hA_0000_0088);
        chk("mret_redirect", redirect_valid, 1);
        chk("mret_redirect_pc", redirect_pc, 64'h8000_0044);
        chk("mret_commit", commit_valid, 1);
        tick();
        chk("post_mret_redirect", redirect_valid, 0);
        chk("post_mret_redirect_pc_hold", redirect_pc, 64'h8000_0044);

        // reset while in TRAP2: no redirect survives
        in_valid = 1'b1; in_ecall = 1'b1; in_pc = 64'h8000_0200;
        tick();
        in_valid = 1'b0; in_ecall = 1'b0;
        tick();
        chk("trap2b_redirect", redirect_valid, 1);
        reset = 1'b0;
        #1;
        chk("rst_trap2_redirect", redirect_valid, 0);
        chk("rst_trap2_en", wbcsren, 0);
        chk("rst_trap2_mstatus", wbmstatus, 0);
        @(negedge clock) reset = 1'b1;
        tick();
        chk("rst_trap2_after", redirect_valid, 0);

        // back-to-back adds, reset on the third cycle
        in_valid = 1'b1; in_rd_wen = 1'b1; in_rd = 5'd1; in_rd_data = 64'h11;
        tick();
        chk("b2b1_waddr", io_waddr, 1);
        in_rd = 5'd2; in_rd_data = 64'h22;
        tick();
        chk("b2b2_wdata", io_wdata, 64'h22);
        in_rd = 5'd3; in_rd_data = 64'h33;
        reset = 1'b0;
        #1;
        chk("b2b_rst_io_wen", io_wen, 0);
        chk("b2b_rst_io_wdata", io_wdata, 0);
        chk("b2b_rst_commit", commit_valid, 0);
        in_valid = 1'b0;
        @(negedge clock) reset = 1'b1;
        tick(); tick();
        chk("b2b_quiet_io_wen", io_wen, 0);
        chk("b2b_quiet_io_wdata", io_wdata, 0);
`ifdef YSYX_22050550_WBU_MINSTRET_EN
        chk("minstret_rst", minstret, 0);
`endif
        in_valid = 1'b1; in_rd = 5'd4; in_rd_data = 64'h44;
        tick();
        in_valid = 1'b0;
        chk("b2b_new_io_wen", io_wen, 1);
        chk("b2b_new_io_wdata", io_wdata, 64'h44);
        tick();
        chk("b2b_new_idle", io_wen, 0);
`ifdef YSYX_22050550_WBU_MINSTRET_EN
        chk("minstret_one", minstret, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
